// File: rtl/intra_delay_scheduler.sv
// Shared target register fed by per-channel delayed writes ("val = #D data" / "val <= #D data").
// Data is captured at acceptance and applied D cycles later; when several writes land together, the most recent one wins.
module intra_delay_scheduler #(
    parameter int WIDTH = 32,
    parameter int N_CH  = 2,
    parameter int DEPTH = 4,
    parameter int DLY_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            req_valid,
    output logic [N_CH-1:0]            req_ready,
    input  logic [N_CH-1:0]            req_nb,
    input  logic [N_CH*DLY_W-1:0]      req_delay,
    input  logic [N_CH*WIDTH-1:0]      req_data,
    output logic [N_CH-1:0]            done,
    output logic [WIDTH-1:0]           val,
    output logic                       val_changed,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic [31:0]                now
);

    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W  = DLY_W + 1;
    localparam int PEND_W = $clog2(DEPTH + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // Slot storage
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_nb;
    logic [WIDTH-1:0] slot_data [DEPTH];
    logic [DLY_W-1:0] slot_cnt  [DEPTH];
    logic [AGE_W-1:0] slot_age  [DEPTH];
    logic [CH_W-1:0]  slot_ch   [DEPTH];
    logic [N_CH-1:0]  blocked;

    logic              free_found;
    logic [SLOT_W-1:0] free_idx;

    logic              acc_fire;
    logic [CH_W-1:0]   acc_ch;
    logic              acc_nb;
    logic [DLY_W-1:0]  acc_cnt;
    logic [WIDTH-1:0]  acc_data;
    logic [N_CH-1:0]   acc_block;

    logic [DEPTH-1:0]  mature;
    logic              win_found;
    logic [SLOT_W-1:0] win_idx;
    logic [AGE_W-1:0]  win_age;
    logic [N_CH-1:0]   done_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!slot_valid[k] && !free_found) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(k);
            end
        end
    end

    // A lower channel that is valid and could be served takes the single acceptance for this edge.
    always_comb begin
        logic claimed;
        logic eligible;
        claimed   = 1'b0;
        eligible  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible     = rst_n && free_found && !blocked[i];
            req_ready[i] = eligible && !claimed;
            if (req_valid[i] && eligible) begin
                claimed = 1'b1;
            end
        end
    end

    always_comb begin
        acc_fire = 1'b0;
        acc_ch   = '0;
        acc_nb   = 1'b0;
        acc_cnt  = '0;
        acc_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_fire = 1'b1;
                acc_ch   = CH_W'(i);
                acc_nb   = req_nb[i];
                acc_cnt  = (req_delay[i*DLY_W +: DLY_W] == '0) ? DLY_W'(1)
                                                               : req_delay[i*DLY_W +: DLY_W];
                acc_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Last-write-wins: among maturing slots the youngest (smallest age) drives val.
    always_comb begin
        mature    = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_age   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            mature[k] = slot_valid[k] && (slot_cnt[k] == DLY_W'(1));
            if (mature[k] && (!win_found || slot_age[k] < win_age)) begin
                win_found = 1'b1;
                win_idx   = SLOT_W'(k);
                win_age   = slot_age[k];
            end
        end
    end

    // Every maturing blocking slot releases its channel, even one that lost the collision.
    always_comb begin
        done_next = '0;
        acc_block = '0;
        for (int c = 0; c < N_CH; c++) begin
            acc_block[c] = acc_fire && !acc_nb && (acc_ch == CH_W'(c));
            for (int k = 0; k < DEPTH; k++) begin
                if (mature[k] && !slot_nb[k] && (slot_ch[k] == CH_W'(c))) begin
                    done_next[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k]) begin
                pending = pending + PEND_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid  <= '0;
            blocked     <= '0;
            done        <= '0;
            val         <= '0;
            val_changed <= 1'b0;
            now         <= '0;
        end else begin
            now <= now + 32'd1;
            for (int k = 0; k < DEPTH; k++) begin
                if (mature[k]) begin
                    slot_valid[k] <= 1'b0;
                end
            end
            // The free slot is never a maturing one, so the set cannot clash with a clear.
            if (acc_fire) begin
                slot_valid[free_idx] <= 1'b1;
            end
            blocked     <= (blocked & ~done_next) | acc_block;
            done        <= done_next;
            val_changed <= win_found && (slot_data[win_idx] != val);
            if (win_found) begin
                val <= slot_data[win_idx];
            end
        end
    end

    // NOTE: slot payload has no reset; slot_valid alone qualifies it, so the storage stays plain flops.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_valid[k] && slot_cnt[k] > DLY_W'(1)) begin
                slot_cnt[k] <= slot_cnt[k] - DLY_W'(1);
                slot_age[k] <= (slot_age[k] == AGE_MAX) ? slot_age[k] : slot_age[k] + AGE_W'(1);
            end
        end
        if (acc_fire) begin
            slot_data[free_idx] <= acc_data;
            slot_cnt[free_idx]  <= acc_cnt;
            slot_age[free_idx]  <= '0;
            slot_ch[free_idx]   <= acc_ch;
            slot_nb[free_idx]   <= acc_nb;
        end
    end

endmodule

// File: tb/tb_intra_delay_scheduler.sv
// Scoreboard bench for intra_delay_scheduler: each accepted request is queued with its apply cycle,
// and a negedge monitor retires due entries and compares val, val_changed, done, pending and now.
module tb_intra_delay_scheduler;

    localparam int WIDTH = 32;
    localparam int N_CH  = 2;
    localparam int DEPTH = 4;
    localparam int DLY_W = 4;
    localparam int PEND_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_CH-1:0]        req_valid;
    logic [N_CH-1:0]        req_ready;
    logic [N_CH-1:0]        req_nb;
    logic [N_CH*DLY_W-1:0]  req_delay;
    logic [N_CH*WIDTH-1:0]  req_data;
    logic [N_CH-1:0]        done;
    logic [WIDTH-1:0]       val;
    logic                   val_changed;
    logic [PEND_W-1:0]      pending;
    logic [31:0]            now;

    intra_delay_scheduler #(
        .WIDTH(WIDTH), .N_CH(N_CH), .DEPTH(DEPTH), .DLY_W(DLY_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_nb(req_nb),
        .req_delay(req_delay), .req_data(req_data),
        .done(done), .val(val), .val_changed(val_changed),
        .pending(pending), .now(now)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          apply_at;
        logic [31:0] data;
        int          ch;
        bit          nb;
        int          seq;
    } pend_t;

    pend_t       q[$];
    int          seq_cnt = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          tb_now;
    logic [31:0] mval = '0;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_now <= 0;
        else        tb_now <= tb_now + 1;
    end

    // Retire every entry due at the edge just past; the most recently accepted one sets val.
    always @(negedge clk) begin : mon
        int              lbl;
        int              best;
        logic [31:0]     nv;
        logic [N_CH-1:0] dn;
        bit              have;
        if (rst_n && mon_en) begin
            lbl  = tb_now - 1;
            best = -1;
            nv   = mval;
            dn   = '0;
            have = 1'b0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].apply_at == lbl) begin
                    if (!q[k].nb) dn[q[k].ch] = 1'b1;
                    if (q[k].seq > best) begin
                        best = q[k].seq;
                        nv   = q[k].data;
                        have = 1'b1;
                    end
                end
            end
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].apply_at == lbl) q.delete(k);
            end
            check("val_changed", val_changed, have && (nv != mval));
            mval = nv;
            check("val", val, mval);
            check("done", done, dn);
            check("pending", pending, q.size());
            check("now", now, tb_now);
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic issue(input int ch, input bit nb, input int d, input logic [31:0] data,
                         output int lbl);
        int    waited;
        pend_t e;
        waited = 0;
        lbl    = -1;
        req_nb[ch]                  = nb;
        req_delay[ch*DLY_W +: DLY_W] = DLY_W'(d);
        req_data[ch*WIDTH +: WIDTH]  = data;
        req_valid[ch]               = 1'b1;
        #1;
        while (!req_ready[ch] && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("accept_in_budget", req_ready[ch], 1'b1);
        if (req_ready[ch]) begin
            lbl        = tb_now;
            e.apply_at = lbl + ((d == 0) ? 1 : d);
            e.data     = data;
            e.ch       = ch;
            e.nb       = nb;
            e.seq      = seq_cnt;
            seq_cnt++;
            q.push_back(e);
        end
        @(negedge clk);
        req_valid[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int l0, l1, la, lb, lf, l5, lx;
        req_valid = '0;
        req_nb    = '0;
        req_delay = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 2'b00);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        #1;
        check("rst_val", val, 0);
        check("rst_pending", pending, 0);
        check("rst_now", now, 0);
        check("rst_done", done, 0);
        check("rst_changed", val_changed, 0);
        check("post_rst_ready", req_ready, 2'b11);

        // Blocking request accepted at now=10 with D=10
        while (tb_now != 10) @(negedge clk);
        issue(0, 1'b0, 10, 32'd3, l0);
        check("t1_accept_now", l0, 10);
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t1_ready_blocked", req_ready[0], 1'b0);
            @(negedge clk);
        end
        #1;
        check("t1_ready_back", req_ready[0], 1'b1);
        check("t1_val", val, 3);
        check("t1_done", done, 2'b01);
        @(negedge clk);
        check("t1_done_once", done, 2'b00);

        // Collision: older write (4) must lose to younger write (6)
        drain();
        issue(0, 1'b1, 5, 32'd4, l0);
        issue(1, 1'b1, 4, 32'd6, l1);
        check("t2_back_to_back", l1, l0 + 1);
        drain();
        check("t2_val", val, 6);

        // Equal value gives no pulse; D=0 acts as D=1
        issue(0, 1'b1, 1, 32'd7, lx);
        drain();
        issue(0, 1'b1, 2, 32'd7, lx);
        drain();
        check("t4_val_same", val, 7);
        issue(1, 1'b1, 0, 32'd9, lx);
        #1;
        check("t4_d0_not_early", val, 7);
        @(negedge clk);
        check("t4_d0_apply", val, 9);
        drain();

        // Priority between channels, and a blocked ch0 not stalling ch1
        fork
            issue(0, 1'b1, 3, 32'h11, la);
            issue(1, 1'b1, 3, 32'h22, lb);
        join
        check("t5_prio", lb, la + 1);
        drain();
        issue(0, 1'b0, 8, 32'h33, l0);
        fork
            issue(0, 1'b0, 1, 32'h44, la);
            issue(1, 1'b1, 3, 32'h55, lb);
        join
        check("t5_ch1_bypass", lb, l0 + 1);
        check("t5_ch0_after_done", la, l0 + 9);
        drain();

        // Full: four D=15 slots, fifth waits for the first apply
        issue(0, 1'b1, 15, 32'd100, lf);
        for (int i = 1; i < 4; i++) issue(0, 1'b1, 15, 32'd100 + 32'(i), lx);
        #1;
        check("t3_pending_full", pending, 4);
        check("t3_ready_full", req_ready, 2'b00);
        issue(0, 1'b1, 15, 32'd104, l5);
        check("t3_ready_return", l5, lf + 16);
        drain();

        // Reset with three writes in flight
        for (int i = 0; i < 3; i++) issue(0, 1'b1, 12, 32'h70 + 32'(i), lx);
        #1;
        check("t6_pending_before", pending, 3);
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1;
        check("t6_val", val, 0);
        check("t6_pending", pending, 0);
        check("t6_now", now, 0);
        q.delete();
        mval = '0;
        repeat (2) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_late_val", val, 0);
        check("t6_no_late_pending", pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
